// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce scheduler: channel state encodings and
// a ceiling-log2 helper used to size the grant index.
package debounce_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    PENDING = 2'd1,
    TIMING  = 2'd2,
    HELD    = 2'd3
  } chan_state_e;

  // Returns at least 1 so a single-bit index is produced for small counts.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer for the active-low button and the
// request/timing/held state machine that produces the confirmed-press pulse.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ARMED   | idle, waiting for a synchronized press
// PENDING | press seen, requesting the shared timer
// TIMING  | owns the shared timer, input ignored until evaluation
// HELD    | press confirmed and pulsed, waiting for release
module debounce_channel
  import debounce_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  input  logic grant,
  input  logic timer_done,
  output logic req,
  output logic press_pulse
);

  logic        sync_q1;
  logic        s;
  chan_state_e state;
  chan_state_e state_nxt;
  logic        pulse_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1     <= 1'b0;
      s           <= 1'b0;
      state       <= ARMED;
      press_pulse <= 1'b0;
    end else begin
      sync_q1     <= ~btn_n;
      s           <= sync_q1;
      state       <= state_nxt;
      press_pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pulse_nxt = 1'b0;
    case (state)
      ARMED: begin
        if (s) state_nxt = PENDING;
      end
      PENDING: begin
        if (!s)         state_nxt = ARMED;
        else if (grant) state_nxt = TIMING;
      end
      TIMING: begin
        if (timer_done) begin
          if (s) begin
            state_nxt = HELD;
            pulse_nxt = 1'b1;
          end else begin
            state_nxt = ARMED;
          end
        end
      end
      HELD: begin
        if (!s) state_nxt = ARMED;
      end
      default: state_nxt = ARMED;
    endcase
  end

  assign req = (state == PENDING) && s;

endmodule

// File: rtl/debounce_scheduler.sv
// Debounces NUM_BTNS active-low buttons with one shared wait counter, handed
// to requesting channels by a round-robin arbiter.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int NUM_BTNS      = 4,
  parameter int MAX_CLK_COUNT = 480000 - 1,
  parameter int CNT_WIDTH     = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BTNS-1:0]           btn_n,
  output logic [NUM_BTNS-1:0]           press_pulse,
  output logic                          busy,
  output logic [clog2(NUM_BTNS)-1:0]    grant_id
);

  localparam int ID_W = clog2(NUM_BTNS);

  logic [NUM_BTNS-1:0]  req;
  logic [NUM_BTNS-1:0]  grant_vec;
  logic [NUM_BTNS-1:0]  done_vec;
  logic [CNT_WIDTH-1:0] cnt;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_vld;
  logic                 timer_eval;
  logic                 cooldown;
  int                   idx;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    debounce_channel u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn_n       (btn_n[i]),
      .grant       (grant_vec[i]),
      .timer_done  (done_vec[i]),
      .req         (req[i]),
      .press_pulse (press_pulse[i])
    );
  end

  assign timer_eval = busy && (cnt == CNT_WIDTH'(MAX_CLK_COUNT));

  // The cycle right after an evaluation is held idle so consecutive grants
  // are always separated by a full cycle with the timer free.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_BTNS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_BTNS) idx = idx - NUM_BTNS;
      if (!grant_vld && req[idx] && !busy && !cooldown) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    done_vec  = '0;
    if (grant_vld)  grant_vec[grant_idx] = 1'b1;
    if (timer_eval) done_vec[grant_id]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      grant_id <= '0;
      cnt      <= '0;
      rr_ptr   <= '0;
      cooldown <= 1'b0;
    end else begin
      cooldown <= timer_eval;
      if (busy) begin
        if (timer_eval) busy <= 1'b0;
        else            cnt  <= cnt + CNT_WIDTH'(1);
      end else if (grant_vld) begin
        busy     <= 1'b1;
        grant_id <= grant_idx;
        cnt      <= '0;
        rr_ptr   <= (grant_idx == ID_W'(NUM_BTNS - 1)) ? '0 : grant_idx + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with NUM_BTNS=4, MAX_CLK_COUNT=9.
module tb_debounce_scheduler;

  localparam int NB  = 4;
  localparam int MAX = 9;

  logic          clk;
  logic          rst;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] press_pulse;
  logic          busy;
  logic [1:0]    grant_id;

  int vectors;
  int miscompares;

  debounce_scheduler #(
    .NUM_BTNS      (NB),
    .MAX_CLK_COUNT (MAX),
    .CNT_WIDTH     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .press_pulse (press_pulse),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    btn_n = '1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int n = 0; n < 100; n++) begin
      if (n > 0) tick();
      vectors++;
      if (press_pulse !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_pulse cycle %0d: got %b want 0000", n, press_pulse);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy cycle %0d: got %b want 0", n, busy);
      end
      vectors++;
      if (grant_id !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_grant_id cycle %0d: got %0d want 0", n, grant_id);
      end
    end
  endtask

  task automatic test_single_press();
    logic [NB-1:0] exp_pulse;
    logic          exp_busy;
    btn_n[2] = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      exp_pulse = (n == 14) ? 4'b0100 : 4'b0000;
      exp_busy  = (n >= 4) && (n <= 13);
      vectors++;
      if (press_pulse !== exp_pulse) begin
        miscompares++;
        $display("FAIL single_pulse edge %0d: got %b want %b", n, press_pulse, exp_pulse);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL single_busy edge %0d: got %b want %b", n, busy, exp_busy);
      end
      if (exp_busy) begin
        vectors++;
        if (grant_id !== 2'd2) begin
          miscompares++;
          $display("FAIL single_grant_id edge %0d: got %0d want 2", n, grant_id);
        end
      end
    end
    btn_n = '1;
    repeat (10) begin
      tick();
      vectors++;
      if (press_pulse !== 4'b0000) begin
        miscompares++;
        $display("FAIL single_release pulse: got %b want 0000", press_pulse);
      end
    end
  endtask

  task automatic test_glitch();
    // short glitch, then a bounce train that ends released
    for (int n = 1; n <= 33; n++) begin
      btn_n[1] = (n <= 3) ? 1'b0 : 1'b1;
      tick();
      vectors++;
      if (press_pulse !== 4'b0000) begin
        miscompares++;
        $display("FAIL glitch_pulse edge %0d: got %b want 0000", n, press_pulse);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_busy_end: got %b want 0", busy);
    end
    for (int n = 1; n <= 38; n++) begin
      btn_n[1] = (n <= 8 && ((n - 1) / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      vectors++;
      if (press_pulse !== 4'b0000) begin
        miscompares++;
        $display("FAIL bounce_pulse edge %0d: got %b want 0000", n, press_pulse);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_all_press();
    logic [NB-1:0] exp_pulse;
    logic          exp_busy;
    logic [1:0]    exp_gid;
    apply_reset();
    btn_n = '0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      exp_pulse = '0;
      exp_busy  = 1'b0;
      exp_gid   = 2'd0;
      for (int c = 0; c < NB; c++) begin
        if (n == 14 + 12 * c) exp_pulse[c] = 1'b1;
        if (n >= 4 + 12 * c && n <= 13 + 12 * c) begin
          exp_busy = 1'b1;
          exp_gid  = 2'(c);
        end
      end
      vectors++;
      if (press_pulse !== exp_pulse) begin
        miscompares++;
        $display("FAIL all_pulse edge %0d: got %b want %b", n, press_pulse, exp_pulse);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL all_busy edge %0d: got %b want %b", n, busy, exp_busy);
      end
      if (exp_busy) begin
        vectors++;
        if (grant_id !== exp_gid) begin
          miscompares++;
          $display("FAIL all_grant_id edge %0d: got %0d want %0d", n, grant_id, exp_gid);
        end
      end
    end
    btn_n = '1;
    repeat (10) tick();
  endtask

  task automatic test_rr_zero_three();
    logic [NB-1:0] exp_pulse;
    logic          exp_busy;
    logic [1:0]    exp_gid;
    btn_n[0] = 1'b0;
    btn_n[3] = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      exp_pulse = (n == 14) ? 4'b0001 : (n == 26) ? 4'b1000 : 4'b0000;
      exp_busy  = (n >= 4 && n <= 13) || (n >= 16 && n <= 25);
      exp_gid   = (n <= 13) ? 2'd0 : 2'd3;
      vectors++;
      if (press_pulse !== exp_pulse) begin
        miscompares++;
        $display("FAIL rr_pulse edge %0d: got %b want %b", n, press_pulse, exp_pulse);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL rr_busy edge %0d: got %b want %b", n, busy, exp_busy);
      end
      if (exp_busy) begin
        vectors++;
        if (grant_id !== exp_gid) begin
          miscompares++;
          $display("FAIL rr_grant_id edge %0d: got %0d want %0d", n, grant_id, exp_gid);
        end
      end
    end
    btn_n = '1;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid_wait();
    logic [NB-1:0] exp_pulse;
    logic          exp_busy;
    btn_n[0] = 1'b0;
    repeat (9) tick();
    // granted at edge 4, so the counter now holds 5
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_busy_before: got %b want 1", busy);
    end
    rst   = 1'b1;
    btn_n = '1;
    tick();
    rst = 1'b0;
    for (int n = 0; n <= 20; n++) begin
      if (n > 0) tick();
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_busy cycle %0d: got %b want 0", n, busy);
      end
      vectors++;
      if (press_pulse !== 4'b0000) begin
        miscompares++;
        $display("FAIL midrst_pulse cycle %0d: got %b want 0000", n, press_pulse);
      end
    end
    btn_n[1] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp_pulse = (n == 14) ? 4'b0010 : 4'b0000;
      exp_busy  = (n >= 4) && (n <= 13);
      vectors++;
      if (press_pulse !== exp_pulse) begin
        miscompares++;
        $display("FAIL after_rst_pulse edge %0d: got %b want %b", n, press_pulse, exp_pulse);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL after_rst_busy edge %0d: got %b want %b", n, busy, exp_busy);
      end
      if (exp_busy) begin
        vectors++;
        if (grant_id !== 2'd1) begin
          miscompares++;
          $display("FAIL after_rst_grant_id edge %0d: got %0d want 1", n, grant_id);
        end
      end
    end
    btn_n = '1;
    repeat (5) tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    btn_n       = '1;
    test_reset();
    test_single_press();
    test_glitch();
    test_all_press();
    test_rr_zero_three();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
